// File: rtl/urv_timer_pkg.sv
// ============================================================================
// Module  : urv_timer_pkg
// Brief   : Shared definitions for the uRV time base (CSR IDs, reset divider).
// Revision: 1.0
// ============================================================================
`default_nettype none

`define URV_TIMER_DIV_RESET(clk_f, tmr_f) ((clk_f) / (tmr_f) - 1)

package urv_timer_pkg;

    localparam logic [11:0] CSR_ID_CYCLESL  = 12'hC00;
    localparam logic [11:0] CSR_ID_TIMEL    = 12'hC01;
    localparam logic [11:0] CSR_ID_INSTRETL = 12'hC02;
    localparam logic [11:0] CSR_ID_CYCLESH  = 12'hC80;
    localparam logic [11:0] CSR_ID_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_ID_INSTRETH = 12'hC82;

    localparam int DEFAULT_COUNTER_WIDTH = 40;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } presc_state_t;

    function automatic logic [31:0] timer_div_reset(input int clock_freq, input int timer_freq);
        return 32'(`URV_TIMER_DIV_RESET(clock_freq, timer_freq));
    endfunction

endpackage

`default_nettype wire

// File: rtl/urv_counter.sv
// ============================================================================
// Module  : urv_counter
// Brief   : Width-parameterised wrapping counter, async reset, increment enable.
// Revision: 1.0
// ============================================================================
`default_nettype none

module urv_counter
    import urv_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    // Load takes priority over increment; overflow wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/urv_timer.sv
// ============================================================================
// Module  : urv_timer
// Brief   : Prescaled timer tick plus cycle/time/instret CSR counters.
//           Optional instret counter enabled by macro URV_TIMER_INSTRET_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module urv_timer
    import urv_timer_pkg::*;
#(
    parameter int g_timer_frequency = 1000,
    parameter int g_clock_frequency = 62500000,
    parameter int g_counter_width   = DEFAULT_COUNTER_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                cfg_div_i,
    input  logic                       cfg_div_load_i,
    input  logic                       cfg_enable_i,
    input  logic                       instr_retired_i,
    output logic                       timer_tick_o,
    output logic [31:0]                csr_div_o,
    output logic [g_counter_width-1:0] csr_cycles_o,
    output logic [g_counter_width-1:0] csr_time_o,
    output logic [g_counter_width-1:0] csr_instret_o
);

    localparam logic [31:0] DIV_RESET = timer_div_reset(g_clock_frequency, g_timer_frequency);

    presc_state_t state;
    presc_state_t next_state;
    logic [31:0]  div_reg;
    logic [31:0]  prescaler;
    logic         tick;
    logic         run;
    logic         terminal;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (cfg_enable_i)  next_state = ST_RUN;
            ST_RUN:  if (!cfg_enable_i) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Counting follows the state being entered, so the first enabled edge
    // already advances the prescaler from 0 and a falling enable clears it.
    assign run      = (next_state == ST_RUN);
    assign terminal = run && !cfg_div_load_i && (prescaler == div_reg);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_reg   <= DIV_RESET;
            prescaler <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= terminal;
            if (cfg_div_load_i) begin
                div_reg <= cfg_div_i;
            end
            if (cfg_div_load_i || !run || terminal) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 32'd1;
            end
        end
    end

    assign timer_tick_o = tick;
    assign csr_div_o    = div_reg;

    urv_counter #(.WIDTH(g_counter_width)) u_cycles (
        .clk        (clk_i),
        .rst        (rst_i),
        .inc        (1'b1),
        .load       (1'b0),
        .load_value ('0),
        .count      (csr_cycles_o)
    );

    urv_counter #(.WIDTH(g_counter_width)) u_time (
        .clk        (clk_i),
        .rst        (rst_i),
        .inc        (terminal),
        .load       (1'b0),
        .load_value ('0),
        .count      (csr_time_o)
    );

`ifdef URV_TIMER_INSTRET_EN
    urv_counter #(.WIDTH(g_counter_width)) u_instret (
        .clk        (clk_i),
        .rst        (rst_i),
        .inc        (instr_retired_i),
        .load       (1'b0),
        .load_value ('0),
        .count      (csr_instret_o)
    );
`else
    logic unused_instr_retired;
    assign unused_instr_retired = instr_retired_i;
    assign csr_instret_o        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_urv_timer.sv
// ============================================================================
// Module  : tb_urv_timer
// Brief   : Directed, table-driven bench for urv_timer (URV_TIMER_INSTRET_EN aware).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_urv_timer;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_div;
    logic        cfg_load;
    logic        cfg_en;
    logic        instr;
    logic        tick;
    logic [31:0] csr_div;
    logic [31:0] cycles;
    logic [31:0] tmr;
    logic [31:0] instret;

    logic        wrap_load;
    logic        wrap_inc;
    logic [31:0] wrap_value;
    logic [31:0] wrap_count;

    int vectors = 0;
    int fails   = 0;

    typedef struct {
        logic        en;
        logic        load;
        logic [31:0] div;
        logic        exp_tick;
        int          exp_time;
        logic [31:0] exp_div;
    } vec_t;

    vec_t vecs[$];

    urv_timer #(
        .g_timer_frequency (10),
        .g_clock_frequency (100),
        .g_counter_width   (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_div_i       (cfg_div),
        .cfg_div_load_i  (cfg_load),
        .cfg_enable_i    (cfg_en),
        .instr_retired_i (instr),
        .timer_tick_o    (tick),
        .csr_div_o       (csr_div),
        .csr_cycles_o    (cycles),
        .csr_time_o      (tmr),
        .csr_instret_o   (instret)
    );

    urv_counter #(.WIDTH(32)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .inc        (wrap_inc),
        .load       (wrap_load),
        .load_value (wrap_value),
        .count      (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input int n, input logic en, input logic load, input logic [31:0] div,
                                input logic exp_tick, input int exp_time, input logic [31:0] exp_div);
        vec_t v;
        v.en       = en;
        v.load     = load;
        v.div      = div;
        v.exp_tick = exp_tick;
        v.exp_time = exp_time;
        v.exp_div  = exp_div;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int exp_instret;
        int exp_cycles;

        rst        = 1'b1;
        cfg_en     = 1'b1;
        cfg_load   = 1'b0;
        cfg_div    = 32'd0;
        instr      = 1'b0;
        wrap_load  = 1'b0;
        wrap_inc   = 1'b0;
        wrap_value = 32'd0;

        // Divider 0 -> tick each cycle; load wins at terminal count (div=4 -> 2);
        // enable dropped at prescaler 3 and restored 5 cycles later.
        add(1, 1, 1, 0, 0, 3, 0);
        add(1, 1, 0, 0, 1, 4, 0);
        add(1, 1, 0, 0, 1, 5, 0);
        add(1, 1, 0, 0, 1, 6, 0);
        add(1, 1, 0, 0, 1, 7, 0);
        add(1, 1, 1, 4, 0, 7, 4);
        add(4, 1, 0, 0, 0, 7, 4);
        add(1, 1, 1, 2, 0, 7, 2);
        add(2, 1, 0, 0, 0, 7, 2);
        add(1, 1, 0, 0, 1, 8, 2);
        add(1, 1, 0, 0, 0, 8, 2);
        add(1, 1, 1, 9, 0, 8, 9);
        add(3, 1, 0, 0, 0, 8, 9);
        add(5, 0, 0, 0, 0, 8, 9);
        add(9, 1, 0, 0, 0, 8, 9);
        add(1, 1, 0, 0, 1, 9, 9);
        add(1, 1, 0, 0, 0, 9, 9);

        repeat (3) @(negedge clk);
        check("reset_tick", 64'(tick), 64'd0);
        check("reset_div", 64'(csr_div), 64'd9);
        check("reset_cycles", 64'(cycles), 64'd0);
        check("reset_time", 64'(tmr), 64'd0);
        check("reset_instret", 64'(instret), 64'd0);

        rst = 1'b0;
        exp_instret = 0;
        for (int k = 1; k <= 30; k++) begin
            instr = (k % 2 == 1) && (k <= 13);
            @(negedge clk);
`ifdef URV_TIMER_INSTRET_EN
            if (instr) exp_instret++;
`endif
            check("default_tick", 64'(tick), 64'((k % 10) == 0));
            check("default_cycles", 64'(cycles), 64'(k));
            check("default_time", 64'(tmr), 64'(k / 10));
        end
        instr = 1'b0;
        check("instret_total", 64'(instret), 64'(exp_instret));

        exp_cycles = 30;
        for (int i = 0; i < vecs.size(); i++) begin
            cfg_en   = vecs[i].en;
            cfg_load = vecs[i].load;
            cfg_div  = vecs[i].div;
            @(negedge clk);
            exp_cycles++;
            check($sformatf("vec%0d_tick", i), 64'(tick), 64'(vecs[i].exp_tick));
            check($sformatf("vec%0d_time", i), 64'(tmr), 64'(vecs[i].exp_time));
            check($sformatf("vec%0d_div", i), 64'(csr_div), 64'(vecs[i].exp_div));
            check($sformatf("vec%0d_cycles", i), 64'(cycles), 64'(exp_cycles));
        end
        cfg_load = 1'b0;
        cfg_en   = 1'b1;

        // Asynchronous reset mid-cycle must clear state before the next edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_tick", 64'(tick), 64'd0);
        check("async_cycles", 64'(cycles), 64'd0);
        check("async_time", 64'(tmr), 64'd0);
        check("async_instret", 64'(instret), 64'd0);
        check("async_div", 64'(csr_div), 64'd9);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_tick", 64'(tick), 64'd0);
        check("post_reset_cycles", 64'(cycles), 64'd1);

        wrap_load  = 1'b1;
        wrap_inc   = 1'b1;
        wrap_value = 32'hFFFF_FFFE;
        @(negedge clk);
        wrap_load = 1'b0;
        check("wrap_loaded", 64'(wrap_count), 64'hFFFF_FFFE);
        @(negedge clk);
        check("wrap_max", 64'(wrap_count), 64'hFFFF_FFFF);
        @(negedge clk);
        check("wrap_zero", 64'(wrap_count), 64'h0);
        @(negedge clk);
        check("wrap_one", 64'(wrap_count), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

`default_nettype wire
